nonce_result_scanner: RTL and testbench

// - Downstream of the bitcoin_hash core: after it writes NUM_NONCE final H0 words
//   (one per nonce, nonce = word index) to memory, this block reads them back,

---
 rtl/nonce_result_scanner.sv | 232 +++++++++++++++++++++++
 tb/tb_nonce_result_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_scanner
// Brief    : Reads back NUM_NONCE H0 words over the shared single-port memory,
//            tracks the smallest H0 and its nonce, and counts H0 < target.
//            Optional macro SCAN_WRITEBACK_EN adds a 2-word result writeback.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_result_scanner #(
  parameter int NUM_NONCE = 16,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] hash_addr,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [31:0]       target,
  output logic              done,
  output logic              found,
  output logic [7:0]        hit_count,
  output logic [7:0]        best_nonce,
  output logic [31:0]       best_hash,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int               IDX_W           = 9;
  localparam logic [IDX_W-1:0] C_LAST_IDX      = IDX_W'(NUM_NONCE);
  localparam logic [IDX_W-1:0] C_LAST_ADDR_IDX = IDX_W'(NUM_NONCE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_hash_base;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_target;
  logic               r_done;
  logic               r_found;
  logic [7:0]         r_hit_count;
  logic [7:0]         r_best_nonce;
  logic [31:0]        r_best_hash;

  logic               w_scan_cmp;
  logic               w_last_read;
  logic               w_word_better;
  logic               w_word_hit;
  logic [7:0]         w_cur_nonce;
  logic [31:0]        w_best_hash_nxt;
  logic [7:0]         w_best_nonce_nxt;
  logic [7:0]         w_hit_count_nxt;
  logic               w_found_nxt;

`ifdef SCAN_WRITEBACK_EN
  logic [ADDR_W-1:0]  r_result_base;
  logic               r_mem_we;
  logic [31:0]        r_mem_write_data;
`else
  logic               w_unused_result_addr;
  assign w_unused_result_addr = ^result_addr;
`endif

  assign mem_clk = clk;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_scan_cmp  = 1'b0;
    w_last_read = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // Index 0 only issues an address; data for word j-1 arrives at index j.
        w_scan_cmp  = (r_idx != '0);
        w_last_read = (r_idx == C_LAST_IDX);
        if (w_last_read) begin
`ifdef SCAN_WRITEBACK_EN
          w_state_nxt = S_WRITE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_WRITE: begin
        if (r_idx[0]) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Compare datapath
  // --------------------------------------------------------------------------
  assign w_cur_nonce      = 8'(r_idx - IDX_W'(1));
  assign w_word_better    = w_scan_cmp && (mem_read_data < r_best_hash);
  assign w_word_hit       = w_scan_cmp && (mem_read_data < r_target);
  assign w_best_hash_nxt  = w_word_better ? mem_read_data : r_best_hash;
  assign w_best_nonce_nxt = w_word_better ? w_cur_nonce : r_best_nonce;
  assign w_hit_count_nxt  = (w_word_hit && (r_hit_count != 8'hFF)) ?
                            (r_hit_count + 8'd1) : r_hit_count;
  assign w_found_nxt      = r_found | w_word_hit;

  // --------------------------------------------------------------------------
  // Datapath and memory-port registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx            <= '0;
      r_hash_base      <= '0;
      r_mem_addr       <= '0;
      r_target         <= '0;
      r_done           <= 1'b0;
      r_found          <= 1'b0;
      r_hit_count      <= 8'd0;
      r_best_nonce     <= 8'd0;
      r_best_hash      <= 32'hFFFF_FFFF;
`ifdef SCAN_WRITEBACK_EN
      r_result_base    <= '0;
      r_mem_we         <= 1'b0;
      r_mem_write_data <= 32'd0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hash_base   <= hash_addr;
            r_target      <= target;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_hit_count   <= 8'd0;
            r_best_nonce  <= 8'd0;
            r_best_hash   <= 32'hFFFF_FFFF;
            r_idx         <= '0;
            // First word address goes out now so its data lands at index 1.
            r_mem_addr    <= hash_addr;
`ifdef SCAN_WRITEBACK_EN
            r_result_base <= result_addr;
`endif
          end
        end
        S_READ: begin
          r_best_hash  <= w_best_hash_nxt;
          r_best_nonce <= w_best_nonce_nxt;
          r_hit_count  <= w_hit_count_nxt;
          r_found      <= w_found_nxt;
          if (w_last_read) begin
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
          if (r_idx < C_LAST_ADDR_IDX) begin
            r_mem_addr <= r_hash_base + ADDR_W'(r_idx + IDX_W'(1));
          end
`ifdef SCAN_WRITEBACK_EN
          if (w_last_read) begin
            r_mem_we         <= 1'b1;
            r_mem_addr       <= r_result_base;
            r_mem_write_data <= w_best_hash_nxt;
          end
`endif
        end
        S_WRITE: begin
`ifdef SCAN_WRITEBACK_EN
          r_idx <= r_idx + IDX_W'(1);
          if (!r_idx[0]) begin
            r_mem_addr       <= r_result_base + ADDR_W'(1);
            r_mem_write_data <= {r_found, 7'b0, r_hit_count, 8'b0, r_best_nonce};
          end else begin
            r_mem_we <= 1'b0;
          end
`endif
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign done       = r_done;
  assign found      = r_found;
  assign hit_count  = r_hit_count;
  assign best_nonce = r_best_nonce;
  assign best_hash  = r_best_hash;
  assign mem_addr   = r_mem_addr;

`ifdef SCAN_WRITEBACK_EN
  assign mem_we         = r_mem_we;
  assign mem_write_data = r_mem_write_data;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_result_scanner
// Brief    : Self-checking bench with a synchronous memory model and a
//            min/count reference computed directly from the loaded words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_result_scanner;

  localparam int NN     = 16;
  localparam int ADDR_W = 16;
`ifdef SCAN_WRITEBACK_EN
  localparam int EXP_LAT = NN + 4;
`else
  localparam int EXP_LAT = NN + 2;
`endif

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] hash_addr;
  logic [ADDR_W-1:0] result_addr;
  logic [31:0]       target;
  logic              done;
  logic              found;
  logic [7:0]        hit_count;
  logic [7:0]        best_nonce;
  logic [31:0]       best_hash;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  logic [31:0]       mem [65536];
  logic [31:0]       words [NN];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  int n_vec = 0;
  int n_err = 0;

  nonce_result_scanner #(.NUM_NONCE(NN), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .hash_addr      (hash_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .hit_count      (hit_count),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data one cycle after the address; writes logged.
  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_write_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_hits"},  32'(hit_count), 32'd0);
    chk({tag, "_nonce"}, 32'(best_nonce), 32'd0);
    chk({tag, "_best"},  best_hash, 32'hFFFF_FFFF);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
  endtask

  task automatic run_scan(input logic [ADDR_W-1:0] base, input logic [31:0] tgt,
                          input int pulse_at, input string tag);
    logic [31:0]       e_best;
    logic [7:0]        e_nonce;
    logic [7:0]        e_hits;
    logic              e_found;
    logic [ADDR_W-1:0] rbase;
    int                k;

    e_best  = 32'hFFFF_FFFF;
    e_nonce = 8'd0;
    e_hits  = 8'd0;
    e_found = 1'b0;
    for (int n = 0; n < NN; n++) begin
      mem[base + ADDR_W'(n)] = words[n];
      if (words[n] < e_best) begin
        e_best  = words[n];
        e_nonce = 8'(n);
      end
      if (words[n] < tgt) begin
        if (e_hits != 8'hFF) e_hits = e_hits + 8'd1;
        e_found = 1'b1;
      end
    end
    rbase = base + ADDR_W'(16'h0100);
    wr_addr_q.delete();
    wr_data_q.delete();

    @(negedge clk);
    hash_addr   = base;
    result_addr = rbase;
    target      = tgt;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);

    for (k = 1; k <= 60; k++) begin
      if (k == pulse_at) begin
        start     = 1'b1;
        hash_addr = ~base;
        target    = 32'd0;
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      hash_addr = base;
      target    = tgt;
      if (done) break;
    end
    chk({tag, "_latency"}, 32'(k), 32'(EXP_LAT));
    chk({tag, "_best"},    best_hash, e_best);
    chk({tag, "_nonce"},   32'(best_nonce), 32'(e_nonce));
    chk({tag, "_hits"},    32'(hit_count), 32'(e_hits));
    chk({tag, "_found"},   32'(found), 32'(e_found));

    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_done"}, 32'(done), 32'd1);
    chk({tag, "_hold_best"}, best_hash, e_best);
    chk({tag, "_hold_we"},   32'(mem_we), 32'd0);

`ifdef SCAN_WRITEBACK_EN
    chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk({tag, "_wr0_addr"}, 32'(wr_addr_q[0]), 32'(rbase));
      chk({tag, "_wr0_data"}, wr_data_q[0], e_best);
      chk({tag, "_wr1_addr"}, 32'(wr_addr_q[1]), 32'(rbase + ADDR_W'(1)));
      chk({tag, "_wr1_data"}, wr_data_q[1], {e_found, 7'b0, e_hits, 8'b0, e_nonce});
    end
`else
    chk({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'd0);
`endif
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    hash_addr   = '0;
    result_addr = '0;
    target      = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_values("post_rst");

    // All words FFFFFFFF: nothing below target, best stays at its reset value.
    for (int n = 0; n < NN; n++) words[n] = 32'hFFFF_FFFF;
    run_scan(16'h0040, 32'h0001_0000, 0, "all_ff");

    for (int n = 0; n < NN; n++) words[n] = 32'h8000_0000;
    words[5] = 32'h0000_1234;
    run_scan(16'h0200, 32'h0001_0000, 0, "single_hit");

    for (int n = 0; n < NN; n++) words[n] = 32'hFFFF_FFFF;
    words[3] = 32'h0000_0010;
    words[9] = 32'h0000_0010;
    run_scan(16'h0300, 32'h0000_0011, 0, "tie");

    // Base near the top of the address space wraps to 0x0007.
    for (int n = 0; n < NN; n++) words[n] = 32'h0000_0100 + 32'(n);
    words[0] = 32'h0;
    run_scan(16'hFFF8, 32'h0, 0, "wrap");

    for (int n = 0; n < NN; n++) words[n] = 32'h7000_0000 - 32'(n);
    run_scan(16'hFFF8, 32'h6FFF_FFF5, 0, "wrap_last");

    // Async reset part-way through a scan.
    for (int n = 0; n < NN; n++) words[n] = 32'h0000_0100 + 32'(n);
    for (int n = 0; n < NN; n++) mem[16'h0400 + 16'(n)] = words[n];
    @(negedge clk);
    hash_addr = 16'h0400;
    target    = 32'hFFFF_FFFF;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("mid_rst_idle");
    run_scan(16'h0400, 32'h0000_0105, 0, "after_rst");

    // Stray start mid-scan must not disturb latency or latched inputs.
    for (int n = 0; n < NN; n++) words[n] = 32'h0000_0500 - 32'(n * 3);
    run_scan(16'h0500, 32'h0000_04F0, 5, "pulse");

    // Randomized scans.
    for (int t = 0; t < 24; t++) begin
      logic [31:0]       tgt;
      logic [ADDR_W-1:0] base;
      for (int n = 0; n < NN; n++) begin
        case ($urandom_range(0, 4))
          0: words[n] = 32'hFFFF_FFFF;
          1: words[n] = $urandom_range(0, 1000);
          2: words[n] = $urandom;
          3: words[n] = (n > 0) ? words[n-1] : 32'($urandom);
          default: words[n] = 32'h8000_0000 | 32'($urandom_range(0, 255));
        endcase
      end
      case ($urandom_range(0, 3))
        0: tgt = 32'h0;
        1: tgt = $urandom_range(1, 1000);
        2: tgt = $urandom;
        default: tgt = 32'hFFFF_FFFF;
      endcase
      base = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(16'hFFF0, 16'hFFFF))
                                         : ADDR_W'($urandom_range(0, 16'hFE00));
      run_scan(base, tgt, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 14) : 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
